// File: rtl/qrouting_pkg.sv
// Shared Q-routing node definitions: word width, memory map, table addressing
// and the reward-receive FSM state encoding.
package qrouting_pkg;

  localparam int          WORD_W   = 16;
  localparam logic [15:0] RX_BASE  = 16'h0008;
  localparam logic [15:0] ACT_BASE = 16'h0048;
  localparam logic [15:0] CH_BASE  = 16'h0148;
  localparam logic [15:0] Q_BASE   = 16'h01C8;

  // Word-indexed table entry to byte address; wraps modulo 2^16.
  function automatic logic [15:0] idx2addr(input logic [15:0] base,
                                           input logic [15:0] idx);
    return base + {idx[14:0], 1'b0};
  endfunction

  typedef enum logic [3:0] {
    ST_IDLE, ST_ARMED, ST_RD0, ST_RD1, ST_RD2, ST_CAP, ST_CHK,
    ST_WR_CH, ST_RD_OLD, ST_CMP, ST_WR_Q
  } rx_state_e;

endpackage

// File: rtl/reward_rx.sv
// Reward packet receiver: reads a 3-word packet, validates it, and updates the
// cluster-head and neighbour Q tables. REWARD_RX_QMAX_EN keeps the larger Q.
module reward_rx #(
  parameter int          MAX_NODES = 64,
  parameter logic [15:0] RX_BASE   = qrouting_pkg::RX_BASE,
  parameter logic [15:0] CH_BASE   = qrouting_pkg::CH_BASE,
  parameter logic [15:0] Q_BASE    = qrouting_pkg::Q_BASE
) (
  input  logic        clock,
  input  logic        nrst,
  input  logic        en,
  input  logic        start,
  input  logic [15:0] MY_NODE_ID,
  input  logic [15:0] data_in,
  output logic [15:0] address,
  output logic [15:0] data_out,
  output logic        wr_en,
  output logic        done,
  output logic        err
);
  import qrouting_pkg::*;

  localparam logic [15:0] LP_MAX = 16'(MAX_NODES);

  rx_state_e   r_state, w_next;
  logic [15:0] r_src, r_clu, r_q;
  logic        r_done, r_err;
  logic        w_reject;
`ifdef REWARD_RX_QMAX_EN
  logic [15:0] r_old;
`endif

  assign w_reject = (r_src == MY_NODE_ID) || (r_src >= LP_MAX) || (r_clu >= LP_MAX);
  assign done     = r_done;
  assign err      = r_err;

  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      r_state <= ST_IDLE;
      r_src   <= '0;
      r_clu   <= '0;
      r_q     <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: if (en) begin
          r_done <= 1'b0;
          r_err  <= 1'b0;
        end
        ST_RD1:  r_src <= data_in;
        ST_RD2:  r_clu <= data_in;
        ST_CAP:  r_q   <= data_in;
        ST_CHK:  if (w_reject) begin
          r_done <= 1'b1;
          r_err  <= 1'b1;
        end
        ST_WR_Q: begin
          r_done <= 1'b1;
          r_err  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef REWARD_RX_QMAX_EN
  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst)                 r_old <= '0;
    else if (r_state == ST_CMP) r_old <= data_in;
  end
`endif

  // Bus outputs are pure decode of state and latches, so an async reset
  // drops wr_en immediately.
  always_comb begin
    w_next   = r_state;
    address  = '0;
    data_out = '0;
    wr_en    = 1'b0;
    case (r_state)
      ST_IDLE:  if (en) w_next = ST_ARMED;
      ST_ARMED: if (start) w_next = ST_RD0;
      ST_RD0: begin
        address = RX_BASE;
        w_next  = ST_RD1;
      end
      ST_RD1: begin
        address = RX_BASE + 16'd2;
        w_next  = ST_RD2;
      end
      ST_RD2: begin
        address = RX_BASE + 16'd4;
        w_next  = ST_CAP;
      end
      ST_CAP:   w_next = ST_CHK;
      ST_CHK:   w_next = w_reject ? ST_IDLE : ST_WR_CH;
      ST_WR_CH: begin
        wr_en    = 1'b1;
        address  = idx2addr(CH_BASE, r_clu);
        data_out = r_src;
`ifdef REWARD_RX_QMAX_EN
        w_next   = ST_RD_OLD;
`else
        w_next   = ST_WR_Q;
`endif
      end
      ST_RD_OLD: begin
        address = idx2addr(Q_BASE, r_src);
        w_next  = ST_CMP;
      end
      ST_CMP:   w_next = ST_WR_Q;
      ST_WR_Q: begin
        address  = idx2addr(Q_BASE, r_src);
        data_out = r_q;
`ifdef REWARD_RX_QMAX_EN
        wr_en    = (r_q > r_old);
`else
        wr_en    = 1'b1;
`endif
        w_next   = ST_IDLE;
      end
      default:  w_next = ST_IDLE;
    endcase
  end

endmodule
